tune_player: RTL

- Parametrised successor to the fixed-tune piezo player: plays a note sequence from a writable note memory.
- Drives a complementary piezo pair.
- Adds multiple tunes via a selectable start address, loop mode, abort, and a busy/done handshake.
- Sits beside the tour controller; firmware or the controller loads tunes, then pulses go.

---
 rtl/tune_player.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/tune_player.sv
// Piezo tune player over a writable {half_period,dur} note memory; `define TUNE_PLAYER_ARTIC_EN silences each note's last unit.
// Latency: busy one cycle after an accepted go, 2-clock FETCH/DECODE gap per entry; no backpressure, go is ignored while busy.
module tune_player #(
    parameter int DEPTH    = 32,
    parameter int HP_W     = 17,
    parameter int DUR_W    = 8,
    parameter int DUR_UNIT = 1048576,
    parameter int FAST_SIM = 0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [HP_W+DUR_W-1:0] wr_data,
    input  logic [AW-1:0]         start_addr,
    input  logic                  go,
    input  logic                  loop,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  piezo,
    output logic                  piezo_n
);
    localparam int UNIT = (FAST_SIM != 0) ? DUR_UNIT / 16 : DUR_UNIT;
    localparam int UW   = (UNIT > 1) ? $clog2(UNIT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_PLAY, S_DONE} state_t;

    state_t                r_state, w_next;
    logic [HP_W+DUR_W-1:0] r_mem [DEPTH];
    logic [HP_W+DUR_W-1:0] r_entry;
    logic [AW-1:0]         r_addr, r_start;
    logic                  r_loop, r_piezo;
    logic [HP_W-1:0]       r_hp_cnt;
    logic [UW-1:0]         r_unit_cnt;
    logic [DUR_W-1:0]      r_dur_cnt;

    logic [HP_W-1:0]       w_hp;
    logic [DUR_W-1:0]      w_dur;
    logic                  w_start, w_restart, w_advance;
    logic                  w_unit_wrap, w_note_end, w_last_addr, w_silent;

    assign w_hp        = r_entry[HP_W+DUR_W-1:DUR_W];
    assign w_dur       = r_entry[DUR_W-1:0];
    assign w_start     = (r_state == S_IDLE) && go && !abort;
    assign w_unit_wrap = (r_unit_cnt == UW'(UNIT - 1));
    assign w_note_end  = w_unit_wrap && (r_dur_cnt == DUR_W'(1));
    assign w_last_addr = (r_addr == AW'(DEPTH - 1));

`ifdef TUNE_PLAYER_ARTIC_EN
    assign w_silent = (w_dur >= DUR_W'(2)) && (r_dur_cnt == DUR_W'(1));
`else
    assign w_silent = 1'b0;
`endif

    always_comb begin
        w_next    = r_state;
        w_restart = 1'b0;
        w_advance = 1'b0;
        case (r_state)
            S_IDLE:   if (w_start) w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                if (w_dur != '0) begin
                    w_next = S_PLAY;
                end else if (r_loop) begin
                    w_next    = S_FETCH;
                    w_restart = 1'b1;
                end else begin
                    w_next = S_DONE;
                end
            end
            S_PLAY: begin
                // The last memory entry ends the tune instead of wrapping to entry 0.
                if (w_note_end) begin
                    if (!w_last_addr) begin
                        w_next    = S_FETCH;
                        w_advance = 1'b1;
                    end else if (r_loop) begin
                        w_next    = S_FETCH;
                        w_restart = 1'b1;
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (abort && (r_state == S_FETCH || r_state == S_DECODE || r_state == S_PLAY)) begin
            w_next    = S_DONE;
            w_restart = 1'b0;
            w_advance = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) r_mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_entry    <= '0;
            r_addr     <= '0;
            r_start    <= '0;
            r_loop     <= 1'b0;
            r_piezo    <= 1'b0;
            r_hp_cnt   <= '0;
            r_unit_cnt <= '0;
            r_dur_cnt  <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_addr  <= start_addr;
                r_start <= start_addr;
                r_loop  <= loop;
            end else if (w_restart) begin
                r_addr <= r_start;
            end else if (w_advance) begin
                r_addr <= r_addr + 1'b1;
            end
            // Entry is captured only here, so rewriting the playing slot waits for its next fetch.
            if (r_state == S_FETCH) r_entry <= r_mem[r_addr];

            if (r_state == S_DECODE && w_next == S_PLAY) begin
                r_piezo    <= 1'b0;
                r_hp_cnt   <= '0;
                r_unit_cnt <= '0;
                r_dur_cnt  <= w_dur;
            end else if (r_state == S_PLAY && w_next == S_PLAY) begin
                r_unit_cnt <= w_unit_wrap ? '0 : r_unit_cnt + 1'b1;
                if (w_unit_wrap) r_dur_cnt <= r_dur_cnt - 1'b1;
                if (w_hp == '0 || w_silent) begin
                    r_piezo  <= 1'b0;
                    r_hp_cnt <= '0;
                end else if (r_hp_cnt == w_hp - HP_W'(1)) begin
                    r_piezo  <= ~r_piezo;
                    r_hp_cnt <= '0;
                end else begin
                    r_hp_cnt <= r_hp_cnt + 1'b1;
                end
            end else begin
                r_piezo    <= 1'b0;
                r_hp_cnt   <= '0;
                r_unit_cnt <= '0;
                r_dur_cnt  <= '0;
            end
        end
    end

    assign busy    = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_PLAY);
    assign done    = (r_state == S_DONE);
    assign piezo   = r_piezo;
    assign piezo_n = ~r_piezo;
endmodule
